pipelined_cla_adder: RTL and testbench

Parametrised, pipelined carry-look-ahead adder/subtractor built from 4-bit look-ahead groups. One group per pipeline stage, with the group carry registered between stages. Adds valid/ready flow control, a subtract mode, and carry/overflow flags. Sits wherever a wide add or subtract is needed at full clock rate, and accepts one operation per cycle when not back-pressured.

---
 rtl/cla_pkg.sv | 23 ++
 rtl/cla_group4.sv | 32 +++
 rtl/pipelined_cla_adder.sv | 121 ++++++++++++
 tb/tb_pipelined_cla_adder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-look-ahead adder: group width,
// latency helper and the generate/propagate vector type.
package cla_pkg;

  localparam int GROUP_W = 4;

  typedef struct packed {
    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] p;
  } gp_t;

  function automatic int cla_latency(input int width);
    return width / GROUP_W;
  endfunction

  function automatic gp_t cla_gp(input logic [GROUP_W-1:0] a, input logic [GROUP_W-1:0] b);
    gp_t r;
    r.g = a & b;
    r.p = a ^ b;
    return r;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// Purely combinational 4-bit carry-look-ahead group. Every carry is written as
// a flat sum of products of g/p and ci, so no carry ripples inside the group.
module cla_group4
  import cla_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  gp_t        gp;
  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign gp = cla_gp(a, b);
  assign g  = gp.g;
  assign p  = gp.p;

  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined adder/subtractor: one 4-bit look-ahead group per stage, group carry
// registered between stages, valid/ready flow control with a global stall.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTG = cla_latency(WIDTH);

  if ((WIDTH % GROUP_W) != 0 || WIDTH < GROUP_W) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a positive multiple of 4");
  end

  logic adv;

  // The whole pipeline stalls only when a finished result is refused.
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    localparam int LO   = GROUP_W * k;
    localparam int HI   = LO + GROUP_W;
    localparam bit LAST = (k == NSTG - 1);

    logic              vin;
    logic              ci;
    logic [WIDTH-1:LO] xin;
    logic [WIDTH-1:LO] yin;
    logic [HI-1:0]     s_d;
    logic [3:0]        gs;
    logic              gco;
    logic              gc3;
    logic              v_q;
    logic              c_q;
    logic [HI-1:0]     s_q;

    if (k == 0) begin : g_in
      assign vin = in_valid;
      assign xin = x;
      assign yin = sub ? ~y : y;
      assign ci  = sub | cin;
      assign s_d = gs;
    end else begin : g_in
      assign vin = g_stage[k-1].v_q;
      assign xin = g_stage[k-1].g_fwd.x_q;
      assign yin = g_stage[k-1].g_fwd.y_q;
      assign ci  = g_stage[k-1].c_q;
      assign s_d = {gs, g_stage[k-1].s_q};
    end

    cla_group4 u_group (
      .a  (xin[HI-1:LO]),
      .b  (yin[HI-1:LO]),
      .ci (ci),
      .s  (gs),
      .co (gco),
      .c3 (gc3)
    );

    // NOTE: only valid bits and the visible output registers are reset; the
    // inner data registers are don't-care while their valid bit is low.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        if (LAST) begin
          s_q <= '0;
          c_q <= 1'b0;
        end
      end else if (adv) begin
        v_q <= vin;
        if (vin) begin
          s_q <= s_d;
          c_q <= gco;
        end
      end
    end

    if (!LAST) begin : g_fwd
      logic [WIDTH-1:HI] x_q;
      logic [WIDTH-1:HI] y_q;

      always_ff @(posedge clk) begin
        if (adv && vin) begin
          x_q <= xin[WIDTH-1:HI];
          y_q <= yin[WIDTH-1:HI];
        end
      end
    end else begin : g_out
      logic ovf_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv && vin) begin
          ovf_q <= gco ^ gc3;
        end
      end
    end
  end

  assign out_valid = g_stage[NSTG-1].v_q;
  assign s         = g_stage[NSTG-1].s_q;
  assign cout      = g_stage[NSTG-1].c_q;
  assign ovf       = g_stage[NSTG-1].g_out.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder at WIDTH=16 (latency 4) and WIDTH=4 (latency 1).
module tb_pipelined_cla_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0, sub = 1'b0;
  logic [15:0] x = '0, y = '0;
  logic        in_ready, out_valid, cout, ovf;
  logic [15:0] s;

  logic        in_valid4 = 1'b0, out_ready4 = 1'b1, cin4 = 1'b0, sub4 = 1'b0;
  logic [3:0]  x4 = '0, y4 = '0;
  logic        in_ready4, out_valid4, cout4, ovf4;
  logic [3:0]  s4;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] x, y;
    logic        cin, sub;
    logic [15:0] s;
    logic        co, ov;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        co, ov;
    int          acc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_cla_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  pipelined_cla_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .x(x4), .y(y4),
    .cin(cin4), .sub(sub4), .out_valid(out_valid4), .out_ready(out_ready4),
    .s(s4), .cout(cout4), .ovf(ovf4)
  );

  function automatic vec_t mkx(input logic [15:0] a, input logic [15:0] b, input logic ci,
                               input logic sb_, input logic [15:0] rs, input logic rc, input logic ro);
    vec_t v;
    v.x = a; v.y = b; v.cin = ci; v.sub = sb_; v.s = rs; v.co = rc; v.ov = ro;
    return v;
  endfunction

  // Reference model: wide integer add, overflow from operand/result signs.
  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb_);
    logic [15:0] bb;
    logic [16:0] full;
    logic [15:0] rs;
    bb   = sb_ ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {16'd0, (sb_ ? 1'b1 : ci)};
    rs   = full[15:0];
    return mkx(a, b, ci, sb_, rs, full[16], (a[15] == bb[15]) && (rs[15] != a[15]));
  endfunction

  task automatic run16(input string tag, input vec_t v[$], input bit rnd, input bit lat_chk,
                       input int stall_at, input int stall_len);
    int          i = 0;
    int          n_cyc = 0;
    int          got = 0;
    bit          prev_hold = 1'b0;
    logic [15:0] hs;
    logic        hc, ho, exp_rdy;
    exp_t        e;
    while ((i < v.size() || sb.size() != 0) && n_cyc < 2000) begin
      @(negedge clk);
      n_cyc++;
      if (rnd) out_ready = ($urandom_range(3) != 0);
      else     out_ready = !(n_cyc >= stall_at && n_cyc < stall_at + stall_len);
      if (i < v.size() && (!rnd || $urandom_range(9) > 2)) begin
        in_valid = 1'b1; x = v[i].x; y = v[i].y; cin = v[i].cin; sub = v[i].sub;
      end else begin
        in_valid = 1'b0; x = 16'($urandom); y = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      end
      #1;
      exp_rdy = !(out_valid && !out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL %s in_ready: got %b expected %b", tag, in_ready, exp_rdy);
      end
      if (prev_hold) begin
        checks++;
        if ({s, cout, ovf} !== {hs, hc, ho}) begin
          errors++;
          $display("FAIL %s hold: got %h/%b/%b expected %h/%b/%b", tag, s, cout, ovf, hs, hc, ho);
        end
      end
      prev_hold = out_valid && !out_ready;
      hs = s; hc = cout; ho = ovf;
      if (out_valid && out_ready) begin
        got++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected output: got s=%h expected none", tag, s);
        end else begin
          e = sb.pop_front();
          if ({s, cout, ovf} !== {e.s, e.co, e.ov}) begin
            errors++;
            $display("FAIL %s result: got s=%h cout=%b ovf=%b expected s=%h cout=%b ovf=%b",
                     tag, s, cout, ovf, e.s, e.co, e.ov);
          end
          if (lat_chk) begin
            checks++;
            if (cyc - e.acc != 4) begin
              errors++;
              $display("FAIL %s latency: got %0d expected 4", tag, cyc - e.acc);
            end
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back('{s: v[i].s, co: v[i].co, ov: v[i].ov, acc: cyc});
        i++;
      end
    end
    checks++;
    if (n_cyc >= 2000) begin
      errors++;
      $display("FAIL %s timeout: got %0d pending expected 0", tag, sb.size());
    end
    checks++;
    if (got != v.size()) begin
      errors++;
      $display("FAIL %s count: got %0d results expected %0d", tag, got, v.size());
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s stray output: got out_valid=%b s=%h expected 0", tag, out_valid, s);
      end
    end
    sb.delete();
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, s, cout, ovf} !== {1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset16: got v=%b r=%b s=%h c=%b o=%b expected v=0 r=1 s=0000 c=0 o=0",
               out_valid, in_ready, s, cout, ovf);
    end
    checks++;
    if ({out_valid4, in_ready4, s4, cout4, ovf4} !== {1'b0, 1'b1, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset4: got v=%b r=%b s=%h c=%b o=%b expected v=0 r=1 s=0 c=0 o=0",
               out_valid4, in_ready4, s4, cout4, ovf4);
    end
  endtask

  task automatic test_basic_add;
    vec_t q[$];
    q.push_back(mkx(16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0));
    q.push_back(mkx(16'h0002, 16'h0004, 1'b1, 1'b0, 16'h0007, 1'b0, 1'b0));
    run16("basic_add", q, 1'b0, 1'b1, 1000, 0);
  endtask

  task automatic test_carry_chain;
    vec_t q[$];
    q.push_back(mkx(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
    q.push_back(mkx(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1));
    q.push_back(mkx(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0));
    run16("carry_chain", q, 1'b0, 1'b1, 1000, 0);
  endtask

  task automatic test_subtract;
    vec_t q[$];
    q.push_back(mkx(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0));
    q.push_back(mkx(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0));
    q.push_back(mkx(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1));
    run16("subtract", q, 1'b0, 1'b1, 1000, 0);
  endtask

  task automatic test_back_pressure;
    vec_t q[$];
    for (int i = 1; i <= 8; i++)
      q.push_back(mkx(16'(i), 16'(i), 1'b0, 1'b0, 16'(2 * i), 1'b0, 1'b0));
    run16("back_pressure", q, 1'b0, 1'b0, 7, 3);
  endtask

  task automatic test_reset_midflight;
    vec_t q[$];
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; x = 16'(i + 1); y = 16'h0100; cin = 1'b0; sub = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; x = 16'h1234; y = 16'h1111;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, s, cout, ovf} !== {1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midflight reset: got v=%b r=%b s=%h c=%b o=%b expected v=0 r=1 s=0000 c=0 o=0",
               out_valid, in_ready, s, cout, ovf);
    end
    q.push_back(mkx(16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0));
    run16("midflight_new", q, 1'b0, 1'b1, 1000, 0);
  endtask

  task automatic test_width4;
    logic [3:0] tx[4] = '{4'hB, 4'h5, 4'h3, 4'h8};
    logic [3:0] ty[4] = '{4'h6, 4'h3, 4'h5, 4'h1};
    logic       tc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       tb[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] es[4] = '{4'h1, 4'h9, 4'hE, 4'h7};
    logic       ec[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       eo[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid4 = 1'b1; x4 = tx[i]; y4 = ty[i]; cin4 = tc[i]; sub4 = tb[i];
      #1;
      checks++;
      if ({in_ready4, out_valid4} !== 2'b10) begin
        errors++;
        $display("FAIL w4 idle %0d: got ready=%b valid=%b expected ready=1 valid=0", i, in_ready4, out_valid4);
      end
      @(negedge clk);
      in_valid4 = 1'b0;
      #1;
      checks++;
      if ({out_valid4, s4, cout4, ovf4} !== {1'b1, es[i], ec[i], eo[i]}) begin
        errors++;
        $display("FAIL w4 result %0d: got v=%b s=%h c=%b o=%b expected v=1 s=%h c=%b o=%b",
                 i, out_valid4, s4, cout4, ovf4, es[i], ec[i], eo[i]);
      end
    end
  endtask

  task automatic test_random;
    vec_t q[$];
    for (int i = 0; i < 24; i++)
      q.push_back(mk(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom)));
    run16("random", q, 1'b1, 1'b0, 1000, 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    test_reset;
    test_basic_add;
    test_carry_chain;
    test_subtract;
    test_back_pressure;
    test_reset_midflight;
    test_width4;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
